// File: rtl/time_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : time_seq_checker
//  Purpose  : Tracks a wrapping 3-bit time sequence (0..TIMEOUT, then 0).
//             Hunts until LOCK_COUNT consecutive correct successors are seen,
//             then flags any sequence break, counts errors and timeouts.
//  Ports    : clk, rst_n (async active-low)
//             i_time_valid, i_time_in[2:0], i_clear (sync clear)
//             o_locked, o_seq_err, o_timeout_pulse,
//             o_err_count[7:0], o_timeout_count[7:0] (saturating)
//  Options  : TIME_SEQ_CHECKER_STICKY_ERR_EN - when defined, o_seq_err is
//             sticky until clear/reset; otherwise it pulses once per error.
//  Revision : 1.0 - initial release
// ============================================================================
module time_seq_checker #(
   parameter logic [2:0] TIMEOUT    = 3'd6,
   parameter int         LOCK_COUNT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_time_valid,
   input  logic [2:0] i_time_in,
   input  logic       i_clear,
   output logic       o_locked,
   output logic       o_seq_err,
   output logic       o_timeout_pulse,
   output logic [7:0] o_err_count,
   output logic [7:0] o_timeout_count
);

   localparam logic [2:0] c_LOCK_COUNT = 3'(LOCK_COUNT);

   typedef enum logic [0:0] {
      S_HUNT   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t     r_state;
   logic [2:0] r_prev;
   logic       r_have_prev;
   logic [2:0] r_match_cnt;
   logic       r_seq_err;
   logic       r_timeout_pulse;
   logic [7:0] r_err_count;
   logic [7:0] r_timeout_count;

   logic [2:0] w_succ;
   logic       w_is_succ;
   logic [2:0] w_cnt_inc;

   // Successor never exceeds TIMEOUT, so an out-of-range sample can never match.
   assign w_succ    = (r_prev != TIMEOUT) ? (r_prev + 3'd1) : 3'd0;
   assign w_is_succ = (i_time_in == w_succ);
   assign w_cnt_inc = r_match_cnt + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_HUNT;
         r_prev          <= 3'd0;
         r_have_prev     <= 1'b0;
         r_match_cnt     <= 3'd0;
         r_seq_err       <= 1'b0;
         r_timeout_pulse <= 1'b0;
         r_err_count     <= 8'd0;
         r_timeout_count <= 8'd0;
      end else if (i_clear) begin
         // Clear wins over any sample presented in the same cycle.
         r_state         <= S_HUNT;
         r_prev          <= 3'd0;
         r_have_prev     <= 1'b0;
         r_match_cnt     <= 3'd0;
         r_seq_err       <= 1'b0;
         r_timeout_pulse <= 1'b0;
         r_err_count     <= 8'd0;
         r_timeout_count <= 8'd0;
      end else begin
         r_timeout_pulse <= 1'b0;
`ifdef TIME_SEQ_CHECKER_STICKY_ERR_EN
         // Error flag holds its value until clear or reset.
`else
         r_seq_err       <= 1'b0;
`endif
         if (i_time_valid) begin
            r_prev <= i_time_in;
            case (r_state)
               S_HUNT: begin
                  if (!r_have_prev) begin
                     // First sample after reset/clear only seeds prev.
                     r_have_prev <= 1'b1;
                     r_match_cnt <= 3'd0;
                  end else if (w_is_succ) begin
                     if (w_cnt_inc == c_LOCK_COUNT) begin
                        r_state     <= S_LOCKED;
                        r_match_cnt <= 3'd0;
                     end else begin
                        r_match_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_match_cnt <= 3'd0;
                  end
               end
               S_LOCKED: begin
                  if (w_is_succ) begin
                     if (i_time_in == TIMEOUT) begin
                        r_timeout_pulse <= 1'b1;
                        if (r_timeout_count != 8'hFF)
                           r_timeout_count <= r_timeout_count + 8'd1;
                     end
                  end else begin
                     // The offending sample becomes the new hunt seed.
                     r_seq_err   <= 1'b1;
                     if (r_err_count != 8'hFF)
                        r_err_count <= r_err_count + 8'd1;
                     r_state     <= S_HUNT;
                     r_have_prev <= 1'b1;
                     r_match_cnt <= 3'd0;
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

   assign o_locked        = (r_state == S_LOCKED);
   assign o_seq_err       = r_seq_err;
   assign o_timeout_pulse = r_timeout_pulse;
   assign o_err_count     = r_err_count;
   assign o_timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_time_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_seq_checker
//  Purpose  : Self-checking bench for time_seq_checker (TIMEOUT=6,
//             LOCK_COUNT=2): directed vector table, saturation/clear,
//             randomized traffic against a rule-level model, async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_time_seq_checker;

   localparam logic [2:0] TIMEOUT    = 3'd6;
   localparam int         LOCK_COUNT = 2;
`ifdef TIME_SEQ_CHECKER_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_time_valid;
   logic [2:0] i_time_in;
   logic       i_clear;
   logic       o_locked;
   logic       o_seq_err;
   logic       o_timeout_pulse;
   logic [7:0] o_err_count;
   logic [7:0] o_timeout_count;

   time_seq_checker #(.TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_COUNT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_time_valid    (i_time_valid),
      .i_time_in       (i_time_in),
      .i_clear         (i_clear),
      .o_locked        (o_locked),
      .o_seq_err       (o_seq_err),
      .o_timeout_pulse (o_timeout_pulse),
      .o_err_count     (o_err_count),
      .o_timeout_count (o_timeout_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model (rule level) ----------------
   bit       m_locked;
   int       m_prev;
   bit       m_have;
   int       m_run;
   bit       m_se;
   bit       m_tp;
   int       m_ec;
   int       m_tc;

   function automatic int succ_of(input int p);
      return (p == int'(TIMEOUT)) ? 0 : (p + 1) % 8;
   endfunction

   function automatic void model_reset();
      m_locked = 0; m_prev = 0; m_have = 0; m_run = 0;
      m_se = 0; m_tp = 0; m_ec = 0; m_tc = 0;
   endfunction

   function automatic void model_step(input bit v, input int t, input bit c);
      bit ok;
      m_tp = 0;
      if (!STICKY) m_se = 0;
      if (c) begin
         model_reset();
         return;
      end
      if (!v) return;
      ok = m_have && (t == succ_of(m_prev));
      if (m_locked) begin
         if (ok) begin
            if (t == int'(TIMEOUT)) begin
               m_tp = 1;
               if (m_tc < 255) m_tc++;
            end
         end else begin
            m_se = 1;
            if (m_ec < 255) m_ec++;
            m_locked = 0;
            m_run = 0;
         end
      end else if (!m_have) begin
         m_have = 1;
         m_run = 0;
      end else if (ok) begin
         m_run++;
         if (m_run == LOCK_COUNT) begin
            m_locked = 1;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      m_prev = t;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".locked"},  int'(o_locked),        int'(m_locked));
      chk({tag, ".seq_err"}, int'(o_seq_err),       int'(m_se));
      chk({tag, ".tpulse"},  int'(o_timeout_pulse), int'(m_tp));
      chk({tag, ".err_cnt"}, int'(o_err_count),     m_ec);
      chk({tag, ".to_cnt"},  int'(o_timeout_count), m_tc);
   endtask

   // Drive one cycle; outputs are sampled 1 ns after the edge.
   task automatic drive(input bit v, input int t, input bit c);
      i_time_valid = v;
      i_time_in    = 3'(t);
      i_clear      = c;
      @(posedge clk);
      #1;
      model_step(v, t, c);
   endtask

   task automatic step(input string tag, input bit v, input int t, input bit c);
      drive(v, t, c);
      chk_model(tag);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit v; int t; bit c;
      bit lk; bit se_p; bit se_s; bit tp; int ec; int tc;
   } vec_t;

   vec_t vt[18];

   initial begin
      int exp_se;
      //        v  t  c  lk sep ses tp ec tc
      vt[0]  = '{1, 3, 0, 0, 0, 0, 0, 0, 0};
      vt[1]  = '{1, 4, 0, 0, 0, 0, 0, 0, 0};
      vt[2]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0};  // locked after third sample
      vt[3]  = '{1, 6, 0, 1, 0, 0, 1, 0, 1};  // timeout
      vt[4]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1};  // idle: hold, pulse drops
      vt[5]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1};  // wrap
      vt[6]  = '{1, 1, 0, 1, 0, 0, 0, 0, 1};
      vt[7]  = '{1, 2, 0, 1, 0, 0, 0, 0, 1};
      vt[8]  = '{1, 4, 0, 0, 1, 1, 0, 1, 1};  // skip -> error
      vt[9]  = '{1, 5, 0, 0, 0, 1, 0, 1, 1};
      vt[10] = '{1, 6, 0, 1, 0, 1, 0, 1, 1};  // relock, no pulse on lock edge
      vt[11] = '{1, 7, 0, 0, 1, 1, 0, 2, 1};  // illegal value
      vt[12] = '{1, 0, 0, 0, 0, 1, 0, 2, 1};
      vt[13] = '{1, 1, 0, 1, 0, 1, 0, 2, 1};
      vt[14] = '{1, 2, 1, 0, 0, 0, 0, 0, 0};  // clear with sample
      vt[15] = '{1, 3, 0, 0, 0, 0, 0, 0, 0};  // seed only: cleared sample ignored
      vt[16] = '{1, 4, 0, 0, 0, 0, 0, 0, 0};
      vt[17] = '{1, 5, 0, 1, 0, 0, 0, 0, 0};

      rst_n = 1'b0;
      i_time_valid = 1'b0;
      i_time_in = 3'd0;
      i_clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_model("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         drive(vt[i].v, vt[i].t, vt[i].c);
         exp_se = STICKY ? int'(vt[i].se_s) : int'(vt[i].se_p);
         chk($sformatf("vec%0d.locked", i),  int'(o_locked),        int'(vt[i].lk));
         chk($sformatf("vec%0d.seq_err", i), int'(o_seq_err),       exp_se);
         chk($sformatf("vec%0d.tpulse", i),  int'(o_timeout_pulse), int'(vt[i].tp));
         chk($sformatf("vec%0d.err_cnt", i), int'(o_err_count),     vt[i].ec);
         chk($sformatf("vec%0d.to_cnt", i),  int'(o_timeout_count), vt[i].tc);
      end

      // ---------------- saturation then clear ----------------
      for (int i = 0; i < 300; i++) begin
         step("sat.err", 1, (succ_of(m_prev) + 2) % 8, 0);
         step("sat.re1", 1, succ_of(m_prev), 0);
         step("sat.re2", 1, succ_of(m_prev), 0);
      end
      chk("sat.err_cnt_255", int'(o_err_count), 255);
      chk("sat.locked", int'(o_locked), 1);
      step("sat.clear", 1, succ_of(m_prev), 1);
      chk("clear.err_cnt", int'(o_err_count), 0);
      chk("clear.locked", int'(o_locked), 0);
      step("clear.hold", 1, 2, 1);  // clear held a second cycle
      step("post.clear1", 1, 0, 0);
      step("post.clear2", 1, 1, 0);
      step("post.clear3", 1, 2, 0);

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 3000; i++) begin
         bit v, c;
         int t;
         v = ($urandom_range(0, 9) != 0);
         c = ($urandom_range(0, 149) == 0);
         t = ($urandom_range(0, 9) < 8) ? succ_of(m_prev) : int'($urandom_range(0, 7));
         step("rand", v, t, c);
      end

      // ---------------- async reset while locked ----------------
      step("pre.rst0", 1, 0, 1);
      step("pre.rst1", 1, 3, 0);
      step("pre.rst2", 1, 4, 0);
      step("pre.rst3", 1, 5, 0);
      step("pre.rst4", 1, 6, 0);  // timeout count nonzero
      step("pre.rst5", 1, 1, 0);  // error, count nonzero
      step("pre.rst6", 1, 2, 0);
      step("pre.rst7", 1, 3, 0);
      chk("pre.rst.locked", int'(o_locked), 1);
      #2;
      rst_n = 1'b0;
      #1;  // mid-cycle, no clock edge has occurred
      model_reset();
      chk_model("async_rst");
      // a sample pending across the release must not count as an error
      i_time_valid = 1'b1;
      i_time_in = 3'd5;
      @(posedge clk);
      #1;
      chk_model("in_rst");
      rst_n = 1'b1;
      step("rehunt1", 1, 1, 0);
      step("rehunt2", 1, 2, 0);
      step("rehunt3", 1, 3, 0);
      chk("rehunt.locked", int'(o_locked), 1);
      chk("rehunt.err_cnt", int'(o_err_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/time_seq_checker.md
TIME_SEQ_CHECKER -- requirements
Module: time_seq_checker

Interface
REQ-001 Parameter TIMEOUT, default 3'd6, terminal value of the 3-bit time sequence; the legal range is 1..7.
REQ-002 Parameter LOCK_COUNT, default 2, number of consecutive correct successors needed to lock; the legal range is 1..7.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 time_valid  input  1  time_in carries a sample this cycle.
REQ-006 time_in  input  3  sample from the wrapping time generator.
REQ-007 clear  input  1  synchronous clear of the state, the counters and the sticky flag.
REQ-008 locked  output  1  checker is synchronised to the sequence.
REQ-009 seq_err  output  1  sequence error indication (pulse or sticky, see Configuration).
REQ-010 timeout_pulse  output  1  one-cycle pulse when a locked sample equals TIMEOUT.
REQ-011 err_count  output  8  count of sequence errors, saturating.
REQ-012 timeout_count  output  8  count of timeout events, saturating.

Function
REQ-013 The expected successor of prev SHALL be (prev != TIMEOUT) ? prev+1 : 3'd0, computed mod 8.
REQ-014 FSM states: HUNT and LOCKED; the reset state is HUNT.
REQ-015 Registers: prev (3 bits), have_prev (1 bit), match_cnt (3 bits).
REQ-016 HUNT, valid sample, have_prev=0: prev<=sample; have_prev<=1; match_cnt<=0.
REQ-017 HUNT, valid sample equal to the successor: match_cnt+1; prev<=sample. When match_cnt+1 == LOCK_COUNT, go to LOCKED and set match_cnt<=0.
REQ-018 HUNT, valid sample not equal to the successor: match_cnt<=0; prev<=sample. No error is flagged in HUNT.
REQ-019 LOCKED, valid sample equal to the successor: prev<=sample; remain in LOCKED. If the sample equals TIMEOUT, pulse timeout_pulse and increment timeout_count.
REQ-020 LOCKED, valid sample not equal to the successor:
- seq_err asserts and err_count increments;
- go to HUNT with prev<=sample, have_prev<=1, match_cnt<=0.
REQ-021 A sample greater than TIMEOUT is never a successor; it is handled as a mismatch under REQ-018 or REQ-020.
REQ-022 time_valid=0: all state holds; the pulse outputs are 0.
REQ-023 All outputs are registered. A response appears on the cycle after the sample edge (1-cycle latency).
REQ-024 locked = (state == LOCKED).
REQ-025 Counters saturate at 8'hFF; there is no wrap.
REQ-026 clear=1 takes priority over everything else:
- state<=HUNT and have_prev<=0;
- counters<=0 and sticky<=0;
- a sample in the same cycle is discarded.
REQ-027 clear held for multiple cycles keeps the block in the cleared state.

Reset
REQ-028 While rst_n=0, the block is in this state immediately, independent of clk:
- state=HUNT, prev=0, have_prev=0, match_cnt=0;
- locked=0, seq_err=0, timeout_pulse=0;
- err_count=0, timeout_count=0.
REQ-029 Reset released mid-sequence: the checker rehunts from the first valid sample after release. No error is flagged for the gap.

Configuration
REQ-030 Macro TIME_SEQ_CHECKER_STICKY_ERR_EN.
- Defined: seq_err is set by a LOCKED mismatch and stays 1 until clear or reset.
- Undefined: seq_err is a one-cycle pulse per mismatch.
- err_count behaves identically in both builds.

Verification
REQ-031 Lock: rst_n released; valid samples 3,4,5 -> locked=1 the cycle after sample 5; seq_err=0; err_count=0.
REQ-032 Wrap and timeout: while locked, samples 5,6,0,1 -> timeout_pulse=1 for exactly one cycle, after sample 6; timeout_count=1; locked stays 1.
REQ-033 Error: while locked with prev=2, sample 4 -> the next cycle has locked=0, seq_err=1, err_count=1. Then samples 5,6 -> relocks with no further error.
REQ-034 Illegal value: while locked with prev=6, sample 7 -> seq_err and err_count+1. Sticky build: seq_err stays 1 until clear. Pulse build: seq_err clears after one cycle.
REQ-035 Saturation and clear: force 300 locked mismatch/relock cycles -> err_count=255. Then clear with a simultaneous valid sample -> err_count=0, locked=0, and the sample is ignored.
REQ-036 Async reset: assert rst_n=0 between edges while locked -> outputs go to reset values immediately, without waiting for a clk edge.
